// File: rtl/router_pkg.sv
// Shared definitions for the two-VC mesh router: port indices, sizes and
// helpers for packet field positions and XY dimension-order routing.
package router_pkg;

    localparam int NUM_PORTS = 5;
    localparam int NUM_VC    = 2;

    typedef enum logic [2:0] {
        P_PE = 3'd0,
        P_E  = 3'd1,
        P_W  = 3'd2,
        P_N  = 3'd3,
        P_S  = 3'd4
    } port_e;

    // Destination X sits just below the VC bit, destination Y directly below X.
    function automatic int dest_x_lsb(input int dataW, input int coordW);
        return dataW - 1 - coordW;
    endfunction

    function automatic int dest_y_lsb(input int dataW, input int coordW);
        return dataW - 1 - 2 * coordW;
    endfunction

    function automatic logic [2:0] next_port(input logic [2:0] p);
        return (p >= 3'(NUM_PORTS - 1)) ? 3'd0 : p + 3'd1;
    endfunction

    function automatic port_e route_port(input logic [15:0] dx, input logic [15:0] dy,
                                         input logic [15:0] cx, input logic [15:0] cy);
        if (dx > cx) return P_E;
        if (dx < cx) return P_W;
        if (dy > cy) return P_N;
        if (dy < cy) return P_S;
        return P_PE;
    endfunction

endpackage

// File: rtl/vc_rr_arbiter.sv
// Five-requester round-robin arbiter for one output/VC pair; the pointer
// advances past the winner only when a grant is actually issued.
module vc_rr_arbiter
    import router_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_i,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o
);

    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx;
    logic       found;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        if (en_i) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!found && req_i[idx]) begin
                    gnt_o[idx] = 1'b1;
                    ptr_d      = next_port(idx);
                    found      = 1'b1;
                end
                idx = next_port(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mesh_router_vc.sv
// Five-port XY mesh router with two polarity-interleaved virtual channels.
// Define ROUTER_HOP_CNT_EN to increment a saturating hop field on non-PE hops.
module mesh_router_vc
    import router_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int COORD_W      = 4,
    parameter int CUR_X        = 0,
    parameter int CUR_Y        = 0,
    parameter int BUFFER_DEPTH = 2,
    parameter int HOP_LSB      = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic                            polarity,
    input  logic [NUM_PORTS-1:0]            in_si,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_di,
    output logic [NUM_PORTS-1:0]            in_ri,
    output logic [NUM_PORTS-1:0]            out_so,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] out_do,
    input  logic [NUM_PORTS-1:0]            out_ro
);

    localparam int PW       = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int DEPTH_P2 = 2 ** PW;
    localparam int DX_LSB   = dest_x_lsb(DATA_WIDTH, COORD_W);
    localparam int DY_LSB   = dest_y_lsb(DATA_WIDTH, COORD_W);
    localparam int NQ       = NUM_PORTS * NUM_VC;

    if (HOP_LSB < 0 || HOP_LSB + 8 > DATA_WIDTH) begin : g_bad_hop_lsb
        $error("HOP_LSB places the hop field outside the packet");
    end

    logic                  polarity_q;
    logic [NQ-1:0]         fifoEmpty, fifoFull;
    logic [DATA_WIDTH-1:0] fifoHead [NQ];
    logic [NQ-1:0]         obValid;
    logic [DATA_WIDTH-1:0] obData [NQ];
    logic [NUM_PORTS-1:0]  gnt [NQ];
    logic [NUM_PORTS-1:0]  swValid, popReq;
    logic [DATA_WIDTH-1:0] swHead [NUM_PORTS];
    port_e                 swRoute [NUM_PORTS];
    logic [NUM_PORTS-1:0]  swReq [NUM_PORTS];

    assign polarity = polarity_q;

    always_ff @(posedge clk) begin
        if (reset) polarity_q <= 1'b0;
        else       polarity_q <= ~polarity_q;
    end

    // Input FIFOs: the link phase pushes VC == polarity, the switch phase pops the other VC.
    for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_in
        for (genvar gv = 0; gv < NUM_VC; gv++) begin : g_vc
            logic [DATA_WIDTH-1:0] mem_q [DEPTH_P2];
            logic [PW:0]           wrPtr_q, rdPtr_q;
            logic                  push, pop;

            assign push = in_si[gp] && in_ri[gp] && (polarity_q == 1'(gv));
            assign pop  = popReq[gp] && (polarity_q != 1'(gv));
            assign fifoEmpty[gp*NUM_VC+gv] = (wrPtr_q == rdPtr_q);
            assign fifoFull[gp*NUM_VC+gv]  = ((wrPtr_q - rdPtr_q) == (PW+1)'(BUFFER_DEPTH));
            assign fifoHead[gp*NUM_VC+gv]  = mem_q[rdPtr_q[PW-1:0]];

            always_ff @(posedge clk) begin
                if (reset) begin
                    wrPtr_q <= '0;
                    rdPtr_q <= '0;
                end else begin
                    if (push) begin
                        mem_q[wrPtr_q[PW-1:0]] <= in_di[gp*DATA_WIDTH +: DATA_WIDTH];
                        wrPtr_q                <= wrPtr_q + 1'b1;
                    end
                    if (pop) rdPtr_q <= rdPtr_q + 1'b1;
                end
            end
        end

        assign in_ri[gp]   = polarity_q ? ~fifoFull[gp*NUM_VC+1] : ~fifoFull[gp*NUM_VC];
        assign swValid[gp] = polarity_q ? ~fifoEmpty[gp*NUM_VC] : ~fifoEmpty[gp*NUM_VC+1];
        assign swHead[gp]  = polarity_q ? fifoHead[gp*NUM_VC] : fifoHead[gp*NUM_VC+1];
        assign swRoute[gp] = route_port(16'(swHead[gp][DX_LSB +: COORD_W]),
                                        16'(swHead[gp][DY_LSB +: COORD_W]),
                                        16'(CUR_X), 16'(CUR_Y));
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            swReq[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++)
                swReq[o][i] = swValid[i] && (swRoute[i] == port_e'(o));
        end
    end

    // Each head routes to exactly one output, so OR-ing all grants pops each input at most once.
    always_comb begin
        popReq = '0;
        for (int q = 0; q < NQ; q++) popReq = popReq | gnt[q];
    end

    for (genvar go = 0; go < NUM_PORTS; go++) begin : g_out
        for (genvar gv = 0; gv < NUM_VC; gv++) begin : g_vc
            logic                  obValid_q;
            logic [DATA_WIDTH-1:0] obData_q;
            logic [DATA_WIDTH-1:0] selData;
            logic                  grantAny;

            vc_rr_arbiter u_arb (
                .clk   (clk),
                .reset (reset),
                .en_i  ((polarity_q != 1'(gv)) && !obValid_q),
                .req_i (swReq[go]),
                .gnt_o (gnt[go*NUM_VC+gv])
            );

            assign grantAny              = |gnt[go*NUM_VC+gv];
            assign obValid[go*NUM_VC+gv] = obValid_q;
            assign obData[go*NUM_VC+gv]  = obData_q;

            always_comb begin
                selData = '0;
                for (int i = 0; i < NUM_PORTS; i++)
                    if (gnt[go*NUM_VC+gv][i]) selData = swHead[i];
`ifdef ROUTER_HOP_CNT_EN
                if (go != int'(P_PE) && selData[HOP_LSB +: 8] != 8'hFF)
                    selData[HOP_LSB +: 8] = selData[HOP_LSB +: 8] + 8'd1;
`endif
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    obValid_q <= 1'b0;
                    obData_q  <= '0;
                end else if (grantAny) begin
                    obValid_q <= 1'b1;
                    obData_q  <= selData;
                end else if ((polarity_q == 1'(gv)) && out_ro[go]) begin
                    obValid_q <= 1'b0;
                end
            end
        end

        assign out_so[go] = polarity_q ? obValid[go*NUM_VC+1] : obValid[go*NUM_VC];
        assign out_do[go*DATA_WIDTH +: DATA_WIDTH] =
            !out_so[go] ? '0 : (polarity_q ? obData[go*NUM_VC+1] : obData[go*NUM_VC]);
    end

endmodule

// File: tb/tb_mesh_router_vc.sv
// Directed testbench for mesh_router_vc at node (1,1); hop expectations follow
// whether ROUTER_HOP_CNT_EN is defined for the build.
module tb_mesh_router_vc;

    localparam int DW = 64;
    localparam int PE = 0, E = 1, W = 2, N = 3, S = 4;
`ifdef ROUTER_HOP_CNT_EN
    localparam bit HOP_EN = 1'b1;
`else
    localparam bit HOP_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            polarity;
    logic [4:0]      in_si, in_ri, out_so, out_ro;
    logic [5*DW-1:0] in_di, out_do;
    int              vectors = 0;
    int              miscompares = 0;

    always #5 clk = ~clk;

    mesh_router_vc #(
        .DATA_WIDTH(DW), .COORD_W(4), .CUR_X(1), .CUR_Y(1), .BUFFER_DEPTH(2), .HOP_LSB(0)
    ) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .in_si(in_si), .in_di(in_di), .in_ri(in_ri),
        .out_so(out_so), .out_do(out_do), .out_ro(out_ro)
    );

    function automatic logic [DW-1:0] mkPkt(input logic vc, input logic [3:0] dx, input logic [3:0] dy,
                                            input logic [31:0] payload, input logic [7:0] hop);
        logic [DW-1:0] pk;
        pk        = '0;
        pk[63]    = vc;
        pk[62:59] = dx;
        pk[58:55] = dy;
        pk[39:8]  = payload;
        pk[7:0]   = hop;
        return pk;
    endfunction

    function automatic logic [DW-1:0] hopped(input logic [DW-1:0] pk);
        logic [DW-1:0] r;
        r = pk;
        if (HOP_EN && r[7:0] != 8'hFF) r[7:0] = r[7:0] + 8'd1;
        return r;
    endfunction

    function automatic logic [DW-1:0] outPkt(input int p);
        return out_do[p*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int p, input logic [DW-1:0] pk);
        in_si[p]          = 1'b1;
        in_di[p*DW +: DW] = pk;
    endtask

    task automatic idle();
        in_si = '0;
        in_di = '0;
    endtask

    task automatic waitPol(input logic v);
        for (int i = 0; i < 3 && polarity !== v; i++) tick();
        if (polarity !== v) begin
            miscompares++;
            $display("[TB] FAIL waitPol: polarity got %b want %b", polarity, v);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; out_ro = 5'h1F; idle();
        tick(); tick();
        vectors++; if (polarity !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pol: got %b want 0", polarity); end
        vectors++; if (out_so !== 5'b0) begin miscompares++; $display("[TB] FAIL rst_so: got %b want 00000", out_so); end
        vectors++; if (out_do !== '0) begin miscompares++; $display("[TB] FAIL rst_do: got %h want 0", out_do); end
        vectors++; if (in_ri !== 5'h1F) begin miscompares++; $display("[TB] FAIL rst_ri: got %b want 11111", in_ri); end
        reset = 1'b0;
        tick();
        vectors++; if (polarity !== 1'b1) begin miscompares++; $display("[TB] FAIL pol_toggle1: got %b want 1", polarity); end
        tick();
        vectors++; if (polarity !== 1'b0) begin miscompares++; $display("[TB] FAIL pol_toggle0: got %b want 0", polarity); end
    endtask

    task automatic test_basic_east();
        logic [DW-1:0] p;
        p = mkPkt(1'b0, 4'd2, 4'd1, 32'hCAFE_0001, 8'h10);
        waitPol(1'b0);
        send(PE, p);
        tick(); idle();
        vectors++; if (out_so !== 5'b0) begin miscompares++; $display("[TB] FAIL east_t1: out_so got %b want 00000", out_so); end
        tick();
        vectors++; if (out_so !== 5'b00010) begin miscompares++; $display("[TB] FAIL east_t2_so: got %b want 00010", out_so); end
        vectors++; if (outPkt(E) !== hopped(p)) begin miscompares++; $display("[TB] FAIL east_t2_do: got %h want %h", outPkt(E), hopped(p)); end
        tick(); tick();
        vectors++; if (out_so !== 5'b0) begin miscompares++; $display("[TB] FAIL east_drained: out_so got %b want 00000", out_so); end
    endtask

    task automatic test_rr_tie();
        logic [DW-1:0] w1, n1, w2, n2;
        w1 = mkPkt(1'b1, 4'd1, 4'd1, 32'h0000_0A01, 8'h00);
        n1 = mkPkt(1'b1, 4'd1, 4'd1, 32'h0000_0B01, 8'h00);
        w2 = mkPkt(1'b1, 4'd1, 4'd1, 32'h0000_0A02, 8'h00);
        n2 = mkPkt(1'b1, 4'd1, 4'd1, 32'h0000_0B02, 8'h00);
        waitPol(1'b1);
        send(W, w1); send(N, n1);
        tick(); idle();
        tick();
        vectors++; if (out_so !== 5'b00001) begin miscompares++; $display("[TB] FAIL rr_first_so: got %b want 00001", out_so); end
        vectors++; if (outPkt(PE) !== w1) begin miscompares++; $display("[TB] FAIL rr_first_W: got %h want %h", outPkt(PE), w1); end
        send(W, w2); send(N, n2);
        tick(); idle();
        vectors++; if (out_so !== 5'b0) begin miscompares++; $display("[TB] FAIL rr_vc0_idle: got %b want 00000", out_so); end
        tick();
        vectors++; if (outPkt(PE) !== n1) begin miscompares++; $display("[TB] FAIL rr_second_N: got %h want %h", outPkt(PE), n1); end
        tick(); tick();
        vectors++; if (outPkt(PE) !== w2) begin miscompares++; $display("[TB] FAIL rr_third_W: got %h want %h", outPkt(PE), w2); end
        tick(); tick();
        vectors++; if (outPkt(PE) !== n2) begin miscompares++; $display("[TB] FAIL rr_fourth_N: got %h want %h", outPkt(PE), n2); end
        tick(); tick();
        vectors++; if (out_so !== 5'b0) begin miscompares++; $display("[TB] FAIL rr_drained: got %b want 00000", out_so); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] p1, p2, p3, p4, q1;
        p1 = mkPkt(1'b0, 4'd2, 4'd1, 32'h0000_0101, 8'h00);
        p2 = mkPkt(1'b0, 4'd2, 4'd1, 32'h0000_0102, 8'h00);
        p3 = mkPkt(1'b0, 4'd2, 4'd1, 32'h0000_0103, 8'h00);
        p4 = mkPkt(1'b0, 4'd2, 4'd1, 32'h0000_0104, 8'h00);
        q1 = mkPkt(1'b1, 4'd2, 4'd1, 32'h0000_0201, 8'h00);
        waitPol(1'b0);
        out_ro[E] = 1'b0; send(PE, p1);
        tick();
        out_ro[E] = 1'b1; idle(); send(PE, q1);
        tick();
        out_ro[E] = 1'b0; idle(); send(PE, p2);
        vectors++; if (outPkt(E) !== hopped(p1)) begin miscompares++; $display("[TB] FAIL bp_p1_out: got %h want %h", outPkt(E), hopped(p1)); end
        tick();
        out_ro[E] = 1'b1; idle();
        vectors++; if (outPkt(E) !== hopped(q1)) begin miscompares++; $display("[TB] FAIL bp_vc1_flows: got %h want %h", outPkt(E), hopped(q1)); end
        tick();
        out_ro[E] = 1'b0; send(PE, p3);
        vectors++; if (outPkt(E) !== hopped(p1)) begin miscompares++; $display("[TB] FAIL bp_p1_held: got %h want %h", outPkt(E), hopped(p1)); end
        tick();
        out_ro[E] = 1'b1; idle();
        vectors++; if (in_ri[PE] !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_ri_vc1: got %b want 1", in_ri[PE]); end
        vectors++; if (out_so[E] !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_vc1_empty: got %b want 0", out_so[E]); end
        tick();
        send(PE, p4);
        vectors++; if (in_ri[PE] !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_ri_full: got %b want 0", in_ri[PE]); end
        vectors++; if (outPkt(E) !== hopped(p1)) begin miscompares++; $display("[TB] FAIL bp_p1_last: got %h want %h", outPkt(E), hopped(p1)); end
        tick(); idle();
        tick();
        vectors++; if (outPkt(E) !== hopped(p2)) begin miscompares++; $display("[TB] FAIL bp_p2_out: got %h want %h", outPkt(E), hopped(p2)); end
        tick(); tick();
        vectors++; if (outPkt(E) !== hopped(p3)) begin miscompares++; $display("[TB] FAIL bp_p3_out: got %h want %h", outPkt(E), hopped(p3)); end
        tick(); tick();
        vectors++; if (out_so[E] !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_p4_dropped: got %b want 0", out_so[E]); end
    endtask

    task automatic test_reset_midtraffic();
        logic [DW-1:0] p;
        p = mkPkt(1'b0, 4'd2, 4'd1, 32'h0000_0301, 8'h00);
        waitPol(1'b0);
        out_ro = 5'h00;
        for (int k = 0; k < 3; k++) begin
            send(PE, p); send(W, p);
            tick(); idle();
            tick();
        end
        reset = 1'b1;
        tick();
        vectors++; if (out_so !== 5'b0) begin miscompares++; $display("[TB] FAIL rst2_so: got %b want 00000", out_so); end
        vectors++; if (in_ri !== 5'h1F) begin miscompares++; $display("[TB] FAIL rst2_ri: got %b want 11111", in_ri); end
        vectors++; if (polarity !== 1'b0) begin miscompares++; $display("[TB] FAIL rst2_pol: got %b want 0", polarity); end
        reset = 1'b0; out_ro = 5'h1F;
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++; if (out_so !== 5'b0) begin miscompares++; $display("[TB] FAIL rst2_stale: cycle %0d out_so got %b want 00000", k, out_so); end
        end
    endtask

    task automatic test_hop_count();
        logic [DW-1:0] p, e1, e2;
        p  = mkPkt(1'b0, 4'd2, 4'd1, 32'h0000_0401, 8'hFE);
        e1 = HOP_EN ? mkPkt(1'b0, 4'd2, 4'd1, 32'h0000_0401, 8'hFF) : p;
        e2 = e1;
        waitPol(1'b0);
        send(PE, p);
        tick(); idle();
        tick();
        vectors++; if (outPkt(E) !== e1) begin miscompares++; $display("[TB] FAIL hop_first: got %h want %h", outPkt(E), e1); end
        tick(); tick();
        send(W, e1);
        tick(); idle();
        tick();
        vectors++; if (outPkt(E) !== e2) begin miscompares++; $display("[TB] FAIL hop_saturate: got %h want %h", outPkt(E), e2); end
    endtask

    task automatic test_loopback();
        logic [DW-1:0] p;
        p = mkPkt(1'b0, 4'd1, 4'd1, 32'h0000_0501, 8'h33);
        waitPol(1'b0);
        send(PE, p);
        tick(); idle();
        tick();
        vectors++; if (out_so !== 5'b00001) begin miscompares++; $display("[TB] FAIL loop_so: got %b want 00001", out_so); end
        vectors++; if (outPkt(PE) !== p) begin miscompares++; $display("[TB] FAIL loop_do: got %h want %h", outPkt(PE), p); end
    endtask

    task automatic test_south_route();
        logic [DW-1:0] p;
        p = mkPkt(1'b1, 4'd1, 4'd0, 32'h0000_0601, 8'h01);
        waitPol(1'b1);
        send(N, p);
        tick(); idle();
        tick();
        vectors++; if (out_so !== 5'b10000) begin miscompares++; $display("[TB] FAIL south_so: got %b want 10000", out_so); end
        vectors++; if (outPkt(S) !== hopped(p)) begin miscompares++; $display("[TB] FAIL south_do: got %h want %h", outPkt(S), hopped(p)); end
    endtask

    initial begin
        reset = 1'b1; out_ro = 5'h1F; in_si = '0; in_di = '0;
        test_reset();
        test_basic_east();
        test_rr_tie();
        test_backpressure();
        test_reset_midtraffic();
        test_hop_count();
        test_loopback();
        test_south_route();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
